if_fetch_queue: RTL

- Instruction prefetch queue directly downstream of the IF stage and upstream of the IF/ID register and ID stage.
- Buffers {PC, Instruction} pairs produced by IF, so fetch keeps running while ID is frozen by hazards.
- Drives IF's Freeze input (Freeze = ~in_ready).
- Discards all buffered instructions when a branch is taken.

---
 rtl/if_pkg.sv | 13 +
 rtl/if_fetch_queue_mem.sv | 23 ++
 rtl/if_fetch_queue.sv | 78 +++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared IF-side definitions: fetch word width, bubble encoding,
// and the {pc, inst} bundle passed from IF towards ID.
package if_pkg;

   localparam int WORD_W = 32;
   localparam logic [WORD_W-1:0] NOP_INST = 32'd0;

   typedef struct packed {
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] inst;
   } fetch_pair_t;

endpackage

// File: rtl/if_fetch_queue_mem.sv
// Fetch queue storage: DEPTH x DATA_W, synchronous write,
// asynchronous read, no reset on the array.
module fetch_queue_mem #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 64
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [DATA_W-1:0]        i_wdata,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [DATA_W-1:0]        o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_fetch_queue.sv
// Prefetch queue between IF and the IF/ID register; absorbs ID
// freezes and drops everything buffered on a taken branch.
module if_fetch_queue #(
   parameter int                DEPTH    = 4,
   parameter int                WORD_W   = if_pkg::WORD_W,
   parameter logic [WORD_W-1:0] NOP_INST = if_pkg::NOP_INST
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [WORD_W-1:0]          in_pc,
   input  logic [WORD_W-1:0]          in_inst,
   output logic                       in_ready,
   input  logic                       Branch_taken,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic [WORD_W-1:0]          out_pc,
   output logic [WORD_W-1:0]          out_inst,
   output logic [$clog2(DEPTH):0]     count
);

   import if_pkg::*;

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [PW-1:0]       r_wr_ptr;
   logic [PW-1:0]       r_rd_ptr;
   logic [CW-1:0]       r_count;
   logic                w_push;
   logic                w_pop;
   logic [2*WORD_W-1:0] w_wdata;
   logic [2*WORD_W-1:0] w_rdata;

   // Ready depends only on occupancy, so a pop while full
   // cannot open the door for a push in the same cycle.
   assign in_ready  = (r_count != FULL_CNT);
   assign out_valid = (r_count != '0);

   assign w_push = in_valid & in_ready & ~Branch_taken;
   assign w_pop  = out_valid & out_ready & ~Branch_taken;

   assign w_wdata = {in_pc, in_inst};

   fetch_queue_mem #(
      .DEPTH  (DEPTH),
      .DATA_W (2 * WORD_W)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_wdata),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );

   assign out_pc   = out_valid ? w_rdata[2*WORD_W-1:WORD_W] : '0;
   assign out_inst = out_valid ? w_rdata[WORD_W-1:0] : NOP_INST;
   assign count    = r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (Branch_taken) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

endmodule
